cache_replacer: RTL

- Stateful, multi-set replacement-policy unit for the set-associative cache. It holds per-way recency ranks for every set and selects a victim way on request.
- Policy is run-time selectable: true LRU, FIFO, or pseudo-random. Invalid ways are always preferred as victims.
- Sits between the cache lookup stage, which issues touch events, and the miss/refill controller, which issues victim requests.

---
 rtl/cache_replacer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/cache_replacer.sv
// Per-set LRU/FIFO/random victim selector; victim response 1 cycle after an accepted request.
// req_ready drops only during the SET_COUNT-cycle flush; no response backpressure.
// Optional lock_mask port behind CACHE_REPLACER_LOCK_EN; SET_SIZE defaults to `CACHE_E (4 if undefined).
`ifndef CACHE_E
`define CACHE_E 4
`endif

module cache_replacer #(
  parameter int SET_COUNT = 16,
  parameter int SET_SIZE  = `CACHE_E,
  parameter int KEY_WIDTH = $clog2(SET_SIZE),
  parameter int SET_WIDTH = $clog2(SET_COUNT)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [1:0]           mode,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SET_WIDTH-1:0] req_set,
  input  logic [SET_SIZE-1:0]  req_valid_mask,
  output logic                 resp_valid,
  output logic [SET_WIDTH-1:0] resp_set,
  output logic [KEY_WIDTH-1:0] resp_way,
  input  logic                 touch_valid,
  input  logic [SET_WIDTH-1:0] touch_set,
  input  logic [KEY_WIDTH-1:0] touch_way,
  input  logic                 touch_fill,
`ifdef CACHE_REPLACER_LOCK_EN
  input  logic [SET_SIZE-1:0]  lock_mask,
`endif
  output logic                 busy
);

  typedef enum logic {ST_IDLE, ST_FLUSH} state_e;

  state_e                 state_q;
  logic [SET_WIDTH-1:0]   cnt_q;
  logic                   busy_q;
  logic                   rdy_q;
  logic                   resp_valid_q;
  logic [SET_WIDTH-1:0]   resp_set_q;
  logic [KEY_WIDTH-1:0]   resp_way_q;
  logic [15:0]            lfsr_q;
  logic [15:0]            lfsr_d;
  logic [KEY_WIDTH-1:0]   rank_q [SET_COUNT][SET_SIZE];

  logic                   req_fire;
  logic                   inv_found;
  logic [KEY_WIDTH-1:0]   inv_way;
  logic [KEY_WIDTH-1:0]   old_way;
  logic [KEY_WIDTH-1:0]   rnd_way;
  logic [KEY_WIDTH-1:0]   victim_d;
  logic [KEY_WIDTH-1:0]   touch_rank;
  logic                   touch_upd;

  assign req_fire   = req_valid && rdy_q;
  assign req_ready  = rdy_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_set   = resp_set_q;
  assign resp_way   = resp_way_q;

  // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = SET_SIZE - 1; w >= 0; w--) begin
      if (!req_valid_mask[w]) begin
        inv_found = 1'b1;
        inv_way   = KEY_WIDTH'(w);
      end
    end
  end

`ifdef CACHE_REPLACER_LOCK_EN
  logic                 old_found;
  logic                 rnd_found;
  logic [KEY_WIDTH-1:0] best_rank;
  logic [KEY_WIDTH-1:0] cand;

  // Fully locked set falls back to way 0 through the defaults.
  always_comb begin
    old_found = 1'b0;
    old_way   = '0;
    best_rank = '0;
    rnd_found = 1'b0;
    rnd_way   = '0;
    cand      = '0;
    for (int w = 0; w < SET_SIZE; w++) begin
      if (!lock_mask[w] && (!old_found || rank_q[req_set][w] > best_rank)) begin
        old_found = 1'b1;
        old_way   = KEY_WIDTH'(w);
        best_rank = rank_q[req_set][w];
      end
    end
    for (int k = 0; k < SET_SIZE; k++) begin
      cand = lfsr_q[KEY_WIDTH-1:0] + KEY_WIDTH'(k);
      if (!rnd_found && !lock_mask[cand]) begin
        rnd_found = 1'b1;
        rnd_way   = cand;
      end
    end
  end
`else
  always_comb begin
    old_way = '0;
    for (int w = 0; w < SET_SIZE; w++) begin
      if (rank_q[req_set][w] == KEY_WIDTH'(SET_SIZE - 1)) begin
        old_way = KEY_WIDTH'(w);
      end
    end
    rnd_way = lfsr_q[KEY_WIDTH-1:0];
  end
`endif

  assign victim_d = inv_found          ? inv_way :
                    (mode == 2'd2)     ? rnd_way : old_way;

  assign touch_rank = rank_q[touch_set][touch_way];
  assign touch_upd  = touch_valid && (state_q == ST_IDLE) && ((mode != 2'd1) || touch_fill);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      rdy_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_set_q   <= '0;
      resp_way_q   <= '0;
    end else begin
      resp_valid_q <= req_fire;
      if (req_fire) begin
        resp_set_q <= req_set;
        resp_way_q <= victim_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (flush) begin
            state_q <= ST_FLUSH;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            rdy_q   <= 1'b0;
          end else begin
            rdy_q   <= 1'b1;
          end
        end
        ST_FLUSH: begin
          cnt_q <= cnt_q + SET_WIDTH'(1);
          if (cnt_q == SET_WIDTH'(SET_COUNT - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Ranks stay a permutation: only ways more recent than the touched one age by one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SET_COUNT; s++) begin
        for (int w = 0; w < SET_SIZE; w++) begin
          rank_q[s][w] <= KEY_WIDTH'(w);
        end
      end
    end else if (state_q == ST_FLUSH) begin
      for (int w = 0; w < SET_SIZE; w++) begin
        rank_q[cnt_q][w] <= KEY_WIDTH'(w);
      end
    end else if (touch_upd) begin
      for (int w = 0; w < SET_SIZE; w++) begin
        if (KEY_WIDTH'(w) == touch_way) begin
          rank_q[touch_set][w] <= '0;
        end else if (rank_q[touch_set][w] < touch_rank) begin
          rank_q[touch_set][w] <= rank_q[touch_set][w] + KEY_WIDTH'(1);
        end
      end
    end
  end

endmodule
